// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute-stage M-extension unit:
// Funct3/Funct7 encodings, FSM state type, word width and a sign helper.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_t;

    // Two's-complement negate when neg is set, otherwise pass through.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if;

    logic                      start;
    logic [2:0]                Funct3;
    logic [riscv_pkg::XLEN-1:0] op_a;
    logic [riscv_pkg::XLEN-1:0] op_b;
    logic                      busy;
    logic                      done;
    logic [riscv_pkg::XLEN-1:0] result;

    modport master (
        output start, Funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, Funct3, op_a, op_b,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} pair: shift-add for multiply,
// restoring trial-subtract-shift for divide.
module muldiv_step
    import riscv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nx,
    output logic [XLEN-1:0] lo_nx
);

    logic [XLEN:0]   sum_s;
    logic [XLEN+1:0] diff_s;
    logic            div_unused_s;

    assign div_unused_s = diff_s[XLEN];

    // Single iteration datapath; diff_s top bit is the borrow of the trial subtract.
    always_comb begin
        sum_s  = {(XLEN+1){1'b0}};
        diff_s = {(XLEN+2){1'b0}};
        hi_nx  = hi;
        lo_nx  = lo;
        if (is_div) begin
            diff_s = {1'b0, hi, lo[XLEN-1]} - {2'b00, opnd};
            if (!diff_s[XLEN+1]) begin
                hi_nx = diff_s[XLEN-1:0];
                lo_nx = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = {hi[XLEN-2:0], lo[XLEN-1]};
                lo_nx = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                sum_s = {1'b0, hi} + {1'b0, opnd};
            end else begin
                sum_s = {1'b0, hi};
            end
            hi_nx = sum_s[XLEN:1];
            lo_nx = {sum_s[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are iterated XLEN times,
// then the sign fix is applied while loading the registered result.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       f3_r;
    logic             neg_a_r;
    logic             neg_b_r;
    logic [XLEN-1:0]  hi_r;
    logic [XLEN-1:0]  lo_r;
    logic [XLEN-1:0]  opnd_r;
    logic             busy_r;
    logic             done_r;
    logic [XLEN-1:0]  result_r;

    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              div_zero_s;
    logic [XLEN-1:0]   hi_nx_s;
    logic [XLEN-1:0]   lo_nx_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quot_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   fin_val_s;

    // Operand signedness per Funct3, then magnitudes for the unsigned core.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.Funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            F3_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s    = a_signed_s & bus.op_a[XLEN-1];
        b_neg_s    = b_signed_s & bus.op_b[XLEN-1];
        a_mag_s    = cond_neg(bus.op_a, a_neg_s);
        b_mag_s    = cond_neg(bus.op_b, b_neg_s);
        div_zero_s = bus.Funct3[2] & (bus.op_b == {XLEN{1'b0}});
    end

    muldiv_step u_step (
        .is_div (f3_r[2]),
        .hi     (hi_r),
        .lo     (lo_r),
        .opnd   (opnd_r),
        .hi_nx  (hi_nx_s),
        .lo_nx  (lo_nx_s)
    );

    // Sign fix on the outcome of the final iteration, selected by the latched op.
    always_comb begin
        prod_s = {hi_nx_s, lo_nx_s};
        if (neg_a_r ^ neg_b_r) begin
            prod_fix_s = (~prod_s) + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_fix_s = prod_s;
        end
        quot_fix_s = cond_neg(lo_nx_s, neg_a_r ^ neg_b_r);
        rem_fix_s  = cond_neg(hi_nx_s, neg_a_r);
        case (f3_r)
            F3_MUL:                       fin_val_s = prod_fix_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_val_s = prod_fix_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_val_s = quot_fix_s;
            F3_REM, F3_REMU:              fin_val_s = rem_fix_s;
            default:                      fin_val_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM with counter, iteration registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            f3_r     <= 3'b000;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        f3_r   <= bus.Funct3;
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        if (div_zero_s) begin
                            // Divide by zero: architectural result known at once, no sign fix.
                            state_r  <= FIN;
                            done_r   <= 1'b1;
                            neg_a_r  <= 1'b0;
                            neg_b_r  <= 1'b0;
                            result_r <= bus.Funct3[1] ? bus.op_a : {XLEN{1'b1}};
                        end else begin
                            state_r <= RUN;
                            neg_a_r <= a_neg_s;
                            neg_b_r <= b_neg_s;
                            hi_r    <= {XLEN{1'b0}};
                            lo_r    <= a_mag_s;
                            opnd_r  <= b_mag_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    hi_r <= hi_nx_s;
                    lo_r <= lo_nx_s;
                    if (cnt_r == CNT_W'(XLEN-1)) begin
                        state_r  <= FIN;
                        cnt_r    <= {CNT_W{1'b0}};
                        done_r   <= 1'b1;
                        result_r <= fin_val_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule
